arbitro_descarga: RTL
=====================

ARBITRO_DESCARGA -- requirements
Module: arbitro_descarga

Interface
REQ-001 Parameter: N_REQ, 4, number of requesters sharing the charge/discharge unit (2..8).
REQ-002 Parameter: T_MAX, 16, maximum ESPERA cycles per grant when the timeout is compiled in.
REQ-003 Parameter: T_DESC, 2, DESCARGA length in cycles (>=1).
REQ-004 Port: clk  input  1  single clock, all state changes on posedge.
REQ-005 Port: reset  input  1  synchronous, active-high reset.
REQ-006 Port: req  input  N_REQ  per-requester level request (hold high = keep unit in ESPERA).
REQ-007 Port: gnt  output  N_REQ  one-hot grant, all-zero when idle.
REQ-008 Port: a_e  output  1  unit activate/enable.
REQ-009 Port: c  output  1  unit discharge command.
REQ-010 Port: busy  output  1  high whenever the FSM is not in INICIAL.
REQ-011 Port: timeout  output  1  one-cycle pulse on forced discharge (TIMEOUT_EN only, else tied 0).

Function
REQ-012 FSM states SHALL be INICIAL, ACTIVO, ESPERA, DESCARGA, 2-bit encoded 0..3.
REQ-013 INICIAL: if any req bit high, select winner, register it into gnt, go to ACTIVO next cycle; else stay.
REQ-014 Winner SHALL be the first high req bit scanning from index ptr upward with wrap-around modulo N_REQ.
REQ-015 ACTIVO: lasts exactly 1 cycle; req[winner] high -> ESPERA, low -> INICIAL (no discharge, ptr advances).
REQ-016 ESPERA: stay while req[winner] high; req[winner] low -> DESCARGA.
REQ-017 DESCARGA: lasts exactly T_DESC cycles, then INICIAL.
REQ-018 On every return to INICIAL, ptr SHALL become (winner+1) mod N_REQ and gnt SHALL clear.
REQ-019 Outputs are Moore decodes of state: INICIAL a_e=0 c=0; ACTIVO/ESPERA a_e=1 c=0; DESCARGA a_e=0 c=1.
REQ-020 gnt SHALL stay constant from ACTIVO through DESCARGA; req changes on non-winners are ignored while busy.
REQ-021 Latency: req rising in INICIAL at cycle n -> gnt, a_e, busy high at cycle n+1.
REQ-022 Simultaneous requests SHALL resolve per REQ-014 only; no requester may be granted twice while another holds req continuously.
REQ-023 Unreachable state encodings or out-of-range ptr SHALL recover to INICIAL / ptr=0 next cycle.
REQ-024 ESPERA cycle counter width SHALL be $clog2(T_MAX)+1 bits, cleared on ESPERA entry, no wrap.

Reset
REQ-025 reset high at a posedge SHALL force state INICIAL, ptr=0, counters=0, gnt=0, a_e=0, c=0, busy=0, timeout=0.
REQ-026 Reset mid-operation (any state) SHALL abandon the grant without issuing DESCARGA.
REQ-027 reset SHALL take priority over all other inputs in the same cycle.

Configuration
REQ-028 Macro ARBITRO_TIMEOUT_EN defined: ESPERA exits to DESCARGA after T_MAX cycles even with req[winner] high, timeout pulses 1 cycle on first DESCARGA cycle.
REQ-029 Macro ARBITRO_TIMEOUT_EN undefined: ESPERA is unbounded, counter logic absent, timeout driven constant 0.

Structure
REQ-030 Package arbitro_pkg SHALL hold state encodings (INICIAL..DESCARGA) and default N_REQ/T_MAX/T_DESC values.
REQ-031 Round-robin pick SHALL be a combinational sub-module selector_rr (inputs req, ptr; outputs one-hot winner, valid).
REQ-032 FSM, ptr, counters and output decode stay in arbitro_descarga.

Verification
REQ-033 req=0001 held 5 cycles then 0 -> gnt=0001 cycle 1, a_e=1 cycles 1-5, c=1 for 2 cycles, busy falls after, ptr=1.
REQ-034 req=1111 held continuously from reset -> grants 0001,0010,0100,1000,0001 in order (with TIMEOUT_EN, T_MAX=16).
REQ-035 req=0100 one-cycle pulse -> ACTIVO 1 cycle, return to INICIAL, c never asserted, ptr=3.
REQ-036 TIMEOUT_EN, req=0010 held 40 cycles -> a_e high exactly 1+16 cycles, timeout single pulse, then c for 2 cycles, next grant possible.
REQ-037 reset asserted during ESPERA -> next cycle all outputs 0, state INICIAL, ptr=0, no c pulse.
REQ-038 ptr=3, req=1001 -> gnt=1000 first, then gnt=0001.

Source files
------------

// File: rtl/arbitro_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arbitro_pkg
// Description : Shared definitions for the charge/discharge arbiter:
//               FSM state encodings and default configuration values.
// Revision    : 1.0 - initial release
// ============================================================================
package arbitro_pkg;

    // Default configuration
    localparam int c_N_REQ_DEF  = 4;   // requesters sharing the unit (2..8)
    localparam int c_T_MAX_DEF  = 16;  // max ESPERA cycles per grant (timeout build)
    localparam int c_T_DESC_DEF = 2;   // DESCARGA length in cycles (>=1)

    // FSM state encodings (2-bit, 0..3)
    typedef enum logic [1:0] {
        INICIAL  = 2'd0,
        ACTIVO   = 2'd1,
        ESPERA   = 2'd2,
        DESCARGA = 2'd3
    } state_t;

endpackage : arbitro_pkg
`default_nettype wire

// File: rtl/selector_rr.sv
`default_nettype none
// ============================================================================
// Module      : selector_rr
// Description : Combinational round-robin pick. Scans req_i starting at
//               index ptr_i and moving upward with wrap-around; the first
//               set bit wins.
// Ports       : req_i    [N_REQ-1:0]  request vector
//               ptr_i    [PTR_W-1:0]  scan start index
//               winner_o [N_REQ-1:0]  one-hot winner (zero when none)
//               valid_o               at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module selector_rr #(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N_REQ-1:0] winner_o,
    output logic             valid_o
);

    always_comb begin
        int k;
        k        = 0;
        winner_o = '0;
        valid_o  = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            // ptr_i can exceed N_REQ-1 when N_REQ is not a power of two;
            // two conditional subtractions keep k inside the vector.
            k = int'(ptr_i) + i;
            if (k >= N_REQ) k = k - N_REQ;
            if (k >= N_REQ) k = k - N_REQ;
            if (!valid_o && req_i[k]) begin
                winner_o[k] = 1'b1;
                valid_o     = 1'b1;
            end
        end
    end

endmodule : selector_rr
`default_nettype wire

// File: rtl/arbitro_descarga.sv
`default_nettype none
// ============================================================================
// Module      : arbitro_descarga
// Description : Round-robin arbiter granting one requester at a time access
//               to a shared charge/discharge unit. Sequence per grant:
//               INICIAL -> ACTIVO (1 cycle) -> ESPERA (while req held)
//               -> DESCARGA (T_DESC cycles) -> INICIAL.
//               A request dropped during ACTIVO returns straight to INICIAL
//               without discharging.
// Config      : ARBITRO_TIMEOUT_EN - when defined, ESPERA is bounded to
//               T_MAX cycles and 'timeout' pulses on the forced discharge.
//               When undefined, ESPERA is unbounded and 'timeout' is 0.
// Ports       : clk              clock, rising edge
//               reset            synchronous active-high reset
//               req   [N_REQ-1:0] level requests
//               gnt   [N_REQ-1:0] one-hot grant, zero when idle
//               a_e              unit activate/enable (ACTIVO/ESPERA)
//               c                unit discharge command (DESCARGA)
//               busy             FSM not in INICIAL
//               timeout          one-cycle pulse on forced discharge
// Revision    : 1.0 - initial release
// ============================================================================
module arbitro_descarga
    import arbitro_pkg::*;
#(
    parameter int N_REQ  = c_N_REQ_DEF,
    parameter int T_MAX  = c_T_MAX_DEF,
    parameter int T_DESC = c_T_DESC_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic             a_e,
    output logic             c,
    output logic             busy,
    output logic             timeout
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int DW    = $clog2(T_DESC) + 1;

    // Elaboration-time parameter sanity checks
    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
        $error("N_REQ must be in 2..8");
    end
    if (T_DESC < 1) begin : g_bad_tdesc
        $error("T_DESC must be >= 1");
    end
    if (T_MAX < 1) begin : g_bad_tmax
        $error("T_MAX must be >= 1");
    end

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   idx_q, idx_d;     // index of the current winner
    logic [DW-1:0]      desc_q, desc_d;

    logic [N_REQ-1:0]   w_winner;
    logic               w_valid;
    logic [PTR_W-1:0]   w_win_idx;
    logic [PTR_W-1:0]   w_ptr_next;
    logic               w_req_win;
    logic               w_ptr_bad;

`ifdef ARBITRO_TIMEOUT_EN
    localparam int CW = $clog2(T_MAX) + 1;
    logic [CW-1:0]      esp_q, esp_d;
    logic               timeout_q, timeout_d;
`endif

    selector_rr #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_selector_rr (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .winner_o (w_winner),
        .valid_o  (w_valid)
    );

    // One-hot to index of the selected requester
    always_comb begin
        w_win_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_winner[i]) w_win_idx = PTR_W'(i);
        end
    end

    assign w_ptr_next = (idx_q == PTR_W'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
    // Only the granted requester's line matters while busy
    assign w_req_win  = |(req & gnt_q);
    assign w_ptr_bad  = ({1'b0, ptr_q} >= (PTR_W + 1)'(N_REQ));

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        desc_d  = desc_q;
`ifdef ARBITRO_TIMEOUT_EN
        esp_d     = esp_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            INICIAL: begin
                if (w_valid) begin
                    gnt_d   = w_winner;
                    idx_d   = w_win_idx;
                    state_d = ACTIVO;
                end
            end
            ACTIVO: begin
                if (w_req_win) begin
                    state_d = ESPERA;
`ifdef ARBITRO_TIMEOUT_EN
                    esp_d   = '0;
`endif
                end else begin
                    state_d = INICIAL;
                    gnt_d   = '0;
                    ptr_d   = w_ptr_next;
                end
            end
            ESPERA: begin
                if (!w_req_win) begin
                    state_d = DESCARGA;
                    desc_d  = '0;
                end
`ifdef ARBITRO_TIMEOUT_EN
                else if (esp_q >= CW'(T_MAX - 1)) begin
                    state_d   = DESCARGA;
                    desc_d    = '0;
                    timeout_d = 1'b1;
                end else begin
                    esp_d = esp_q + 1'b1;
                end
`endif
            end
            DESCARGA: begin
                if (desc_q >= DW'(T_DESC - 1)) begin
                    state_d = INICIAL;
                    gnt_d   = '0;
                    ptr_d   = w_ptr_next;
                end else begin
                    desc_d = desc_q + 1'b1;
                end
            end
            default: begin
                state_d = INICIAL;
                gnt_d   = '0;
            end
        endcase

        // A corrupted pointer abandons any grant and restarts the rotation
        if (w_ptr_bad) begin
            state_d = INICIAL;
            gnt_d   = '0;
            ptr_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= INICIAL;
            gnt_q   <= '0;
            ptr_q   <= '0;
            idx_q   <= '0;
            desc_q  <= '0;
`ifdef ARBITRO_TIMEOUT_EN
            esp_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            desc_q  <= desc_d;
`ifdef ARBITRO_TIMEOUT_EN
            esp_q     <= esp_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    // Moore output decode
    assign gnt  = gnt_q;
    assign a_e  = (state_q == ACTIVO) || (state_q == ESPERA);
    assign c    = (state_q == DESCARGA);
    assign busy = (state_q != INICIAL);
`ifdef ARBITRO_TIMEOUT_EN
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

endmodule : arbitro_descarga
`default_nettype wire
